// File: rtl/mbus_pkg.sv
// Shared types and helpers for the 32-bit memory bus responder.
package mbus_pkg;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

  // True when addr is word aligned and falls inside [base, base + 4*2^bits).
  // Arguments are widened to 64 bits so the upper bound never wraps.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input int unsigned bits);
    logic [63:0] span;
    span = 64'd4 << bits;
    return (addr >= base) && ((addr - base) < span) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mbus_sp_ram.sv
// Single-port word RAM with byte write enables and a registered read port.
module mbus_sp_ram #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_W    = 32,
  parameter int BE_W      = DATA_W >> 3
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic [BE_W-1:0]      wr_be,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    rd_data_p1
);

  logic [DATA_W-1:0] mem [1 << ADDR_BITS];

  // Byte-masked write and registered read; output holds when rd_en is low.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be[b]) mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
    if (rd_en) rd_data_p1 <= mem[addr];
  end

endmodule

// File: rtl/mbus_mem_responder.sv
// Memory bus responder: AR/R and AW/W/B serviced from one byte-enabled RAM.
module mbus_mem_responder
  import mbus_pkg::*;
#(
  parameter int                         MBUS_ADDR_WIDTH = 32,
  parameter int                         MBUS_DATA_WIDTH = 32,
  parameter int                         MBUS_DW_B       = MBUS_DATA_WIDTH >> 3,
  parameter int                         MEM_ADDR_BITS   = 10,
  parameter logic [MBUS_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                         B_DEPTH_BITS    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       throttle,
  input  logic [MBUS_ADDR_WIDTH-1:0] mbus_ar_addr,
  input  logic                       mbus_ar_valid,
  output logic                       mbus_ar_ready,
  output logic [MBUS_DATA_WIDTH-1:0] mbus_r_data,
  output logic                       mbus_r_valid,
  input  logic                       mbus_r_ready,
  input  logic [MBUS_ADDR_WIDTH-1:0] mbus_aw_addr,
  input  logic                       mbus_aw_valid,
  output logic                       mbus_aw_ready,
  input  logic [MBUS_DATA_WIDTH-1:0] mbus_w_data,
  input  logic                       mbus_w_valid,
  input  logic [MBUS_DW_B-1:0]       mbus_w_strb,
  output logic                       mbus_b_resp,
  output logic                       mbus_b_valid,
  input  logic                       mbus_b_ready
);

  localparam int B_DEPTH = 1 << B_DEPTH_BITS;

  grant_e                      last_grant;
  logic                        grant_rd, grant_wr, rd_ok, wr_ok;
  logic                        ar_hit, aw_hit;
  logic [MEM_ADDR_BITS-1:0]    ar_idx, aw_idx, ram_addr;
  logic [MBUS_DW_B-1:0]        ram_be;
  logic [MBUS_DATA_WIDTH-1:0]  ram_q_p1;
  logic                        r_vld_p1, rd_hit_p1;
  logic [B_DEPTH_BITS:0]       b_count;
  logic [B_DEPTH_BITS-1:0]     b_wptr, b_rptr;
  logic                        b_mem [B_DEPTH];
  logic                        b_push, b_pop;

  assign ar_hit = addr_in_range(64'(mbus_ar_addr), 64'(BASE_ADDR), MEM_ADDR_BITS);
  assign aw_hit = addr_in_range(64'(mbus_aw_addr), 64'(BASE_ADDR), MEM_ADDR_BITS);
  assign ar_idx = MEM_ADDR_BITS'((mbus_ar_addr - BASE_ADDR) >> 2);
  assign aw_idx = MEM_ADDR_BITS'((mbus_aw_addr - BASE_ADDR) >> 2);

  // The B FIFO is full exactly when the count's top bit is set.
  assign rd_ok = mbus_ar_valid & ~throttle & (~r_vld_p1 | mbus_r_ready);
  assign wr_ok = mbus_aw_valid & mbus_w_valid & ~throttle & ~b_count[B_DEPTH_BITS];

  // Arbitrate the single RAM port; on contention grant the side not served last.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (rd_ok && wr_ok) begin
      if (last_grant == GRANT_WR) grant_rd = 1'b1;
      else                        grant_wr = 1'b1;
    end else begin
      grant_rd = rd_ok;
      grant_wr = wr_ok;
    end
  end

  assign mbus_ar_ready = grant_rd;
  assign mbus_aw_ready = grant_wr;

  assign ram_addr = grant_wr ? aw_idx : ar_idx;
  assign ram_be   = (grant_wr && aw_hit) ? mbus_w_strb : '0;

  mbus_sp_ram #(
    .ADDR_BITS (MEM_ADDR_BITS),
    .DATA_W    (MBUS_DATA_WIDTH),
    .BE_W      (MBUS_DW_B)
  ) u_ram (
    .clk        (clk),
    .rd_en      (grant_rd),
    .wr_be      (ram_be),
    .addr       (ram_addr),
    .wr_data    (mbus_w_data),
    .rd_data_p1 (ram_q_p1)
  );

  // Read response slot and round-robin history (control, reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      last_grant <= GRANT_WR;
    end else begin
      if (grant_rd)          r_vld_p1 <= 1'b1;
      else if (mbus_r_ready) r_vld_p1 <= 1'b0;
      if (grant_rd)          last_grant <= GRANT_RD;
      else if (grant_wr)     last_grant <= GRANT_WR;
    end
  end

  // Range flag travelling with the read beat (data, not reset).
  always_ff @(posedge clk) begin
    if (grant_rd) rd_hit_p1 <= ar_hit;
  end

  // Out-of-range or idle beats present zero on the data bus.
  assign mbus_r_valid = r_vld_p1;
  assign mbus_r_data  = (r_vld_p1 && rd_hit_p1) ? ram_q_p1 : '0;

  assign b_push = grant_wr;
  assign b_pop  = mbus_b_valid & mbus_b_ready;

  // B FIFO pointers and occupancy (control, reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      b_count <= '0;
      b_wptr  <= '0;
      b_rptr  <= '0;
    end else begin
      if (b_push) b_wptr <= b_wptr + 1'b1;
      if (b_pop)  b_rptr <= b_rptr + 1'b1;
      case ({b_push, b_pop})
        2'b10:   b_count <= b_count + 1'b1;
        2'b01:   b_count <= b_count - 1'b1;
        default: b_count <= b_count;
      endcase
    end
  end

  // B FIFO storage: ERR for writes that missed the RAM window.
  always_ff @(posedge clk) begin
    if (b_push) b_mem[b_wptr] <= aw_hit ? RESP_OKAY : RESP_ERR;
  end

  assign mbus_b_valid = (b_count != '0);
  assign mbus_b_resp  = mbus_b_valid ? b_mem[b_rptr] : RESP_OKAY;

endmodule

// File: doc/mbus_mem_responder.md
Name: mbus_mem_responder

Overview:
- Responder (slave) end of the 32-bit memory bus driven by the RVV memory queue. It accepts AR/R and AW/W/B traffic and services it from an internal single-port, byte-enabled word RAM.
- Used as the on-chip scratchpad behind the vector memory queue, and as the bus-functional target in unit benches.
- An external throttle input injects backpressure.

Parameters:
- MBUS_ADDR_WIDTH, 32: byte-address width.
- MBUS_DATA_WIDTH, 32: data width; fixed at 32 in this revision.
- MBUS_DW_B, MBUS_DATA_WIDTH>>3: number of byte strobes.
- MEM_ADDR_BITS, 10: log2 of the RAM depth in words.
- BASE_ADDR, 32'h0000_0000: byte address of RAM word 0; must be aligned to the RAM size.
- B_DEPTH_BITS, 3: log2 of the number of pending write-response entries.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- throttle  in  1  when high, forces mbus_ar_ready and mbus_aw_ready low
- mbus_ar_addr  in  MBUS_ADDR_WIDTH  read byte address
- mbus_ar_valid  in  1  read request valid
- mbus_ar_ready  out  1  read request accepted
- mbus_r_data  out  MBUS_DATA_WIDTH  read data
- mbus_r_valid  out  1  read data valid
- mbus_r_ready  in  1  initiator accepts read data
- mbus_aw_addr  in  MBUS_ADDR_WIDTH  write byte address
- mbus_aw_valid  in  1  write address valid; always equal to mbus_w_valid
- mbus_aw_ready  out  1  accepts AW and W together (there is no separate w_ready)
- mbus_w_data  in  MBUS_DATA_WIDTH  write data
- mbus_w_valid  in  1  write data valid
- mbus_w_strb  in  MBUS_DW_B  byte enables
- mbus_b_resp  out  1  0 = OKAY, 1 = ERR
- mbus_b_valid  out  1  write response valid
- mbus_b_ready  in  1  initiator accepts write response

Behaviour:
- Reset (rst high at a clk edge):
  - Outputs after reset: ar_ready=0, aw_ready=0, r_valid=0, r_data=0, b_valid=0, b_resp=0.
  - The pending-B count, the R slot and the last_grant register (=WRITE) are cleared.
  - RAM contents are not reset.
  - Reset mid-operation discards any held R beat and all queued B responses, with no completion.
- Address decode:
  - Word index = (addr - BASE_ADDR)[MEM_ADDR_BITS+1:2].
  - An access is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^MEM_ADDR_BITS and addr[1:0]==0.
  - Compare at full MBUS_ADDR_WIDTH with no wrap; an address past the top is out of range, not aliased.
- Arbitration (single RAM port, at most one access per cycle):
  - rd_ok = ar_valid & ~throttle & (~r_valid | r_ready).
  - wr_ok = aw_valid & w_valid & ~throttle & (b_count < 2^B_DEPTH_BITS).
  - Only one side ok: grant it.
  - Both ok: round-robin, granting the side opposite last_grant.
  - ar_ready = grant_rd and aw_ready = grant_wr; they are never high in the same cycle.
  - last_grant updates only on a completed handshake.
  - ready is a combinational function of valid; the initiator must not make valid depend on ready.
- Read path:
  - AR handshake in cycle N: RAM read in cycle N; r_valid=1 and r_data valid from cycle N+1 (1-cycle latency).
  - r_data and r_valid hold stable while r_valid & ~r_ready.
  - Back-to-back reads: an AR accepted in the cycle the previous beat drains keeps r_valid high with new data in N+1.
  - An out-of-range read returns r_data = 32'h0; there is no error signal on R.
- Write path:
  - AW handshake in cycle N: bytes with strb=1 are written to the RAM at the clk edge ending cycle N.
  - A read of the same word accepted in N+1 returns the new data.
  - Strobe 0 leaves a byte unchanged; strb=0 writes nothing but still returns OKAY.
  - An out-of-range write is dropped; its response is ERR.
- B queue:
  - FIFO of response bits, 2^B_DEPTH_BITS entries; b_count has B_DEPTH_BITS+1 bits.
  - Each AW handshake pushes one entry; visible as b_valid from cycle N+1.
  - b_valid = (b_count != 0), and b_resp = the head entry.
  - A pop occurs on b_valid & b_ready.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
  - When full, aw_ready=0; a write can proceed in the cycle after a pop.
- throttle: takes effect combinationally in its own cycle and has no effect on the R or B output channels.

Decomposition:
- Package mbus_pkg:
  - RESP_OKAY=1'b0, RESP_ERR=1'b1.
  - typedef grant_e {GRANT_RD, GRANT_WR}.
  - Function addr_in_range(addr, base, bits).
- Sub-module mbus_sp_ram:
  - Single-port synchronous RAM with byte write enables and registered read output.
  - Parameters: depth bits, data width.
- The B response FIFO stays inline: small, count-based.

Test Plan:
- Write 0x0000_0010 data 0xA5A5_1234 strb 4'hF, b_ready=1 -> B OKAY arrives 1 cycle later; a read of 0x10 returns 0xA5A5_1234 with r_valid in the cycle after the AR handshake.
- Write strb 4'b0101 data 0xFFFF_FFFF over 0x1122_3344 -> readback is 0x11FF_33FF.
- ar_valid and aw_valid held high together for 4 cycles, no throttle -> grants alternate, starting with RD after reset (last_grant=WRITE); ar_ready and aw_ready are never high together.
- b_ready=0 with 8 back-to-back writes (B_DEPTH_BITS=3) -> aw_ready=0 on the 9th. Raise b_ready -> 8 responses drain in order, and the 9th write is accepted in the cycle after the first pop.
- Read 0x0000_1000 (beyond 4 KiB) -> r_data=0. Write there -> b_resp=1 and the RAM is unchanged. Misaligned address 0x2 -> treated as out of range in both cases.
- Hold r_ready=0 for 5 cycles after an AR -> r_data is stable and ar_ready=0. Assert rst mid-stall -> the next cycle shows r_valid=0 and b_valid=0.
